// File: rtl/sda_reg_bridge_pkg.sv
// sda_reg_bridge_pkg: shared response codes and FSM encoding for the
// AXI4-Lite to register-bus bridge.
package sda_reg_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/sda_reg_bridge_arb.sv
// sda_reg_bridge_arb: two-way round-robin arbiter between a read candidate
// and a write candidate. One-hot grants; the preference flag flips to the
// opposite type after every grant and starts out preferring reads.
module sda_reg_bridge_arb (
    input  logic clk,
    input  logic srst,
    input  logic en_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);

    logic prefer_rd_q;
    logic prefer_rd_d;

    // A lone candidate always wins; on contention the preferred type wins.
    always_comb begin
        rd_gnt_o = 1'b0;
        wr_gnt_o = 1'b0;
        if (en_i) begin
            if (rd_req_i && wr_req_i) begin
                rd_gnt_o = prefer_rd_q;
                wr_gnt_o = !prefer_rd_q;
            end else begin
                rd_gnt_o = rd_req_i;
                wr_gnt_o = wr_req_i;
            end
        end
    end

    // After any grant, prefer the other transaction type next time.
    always_comb begin
        prefer_rd_d = prefer_rd_q;
        if (rd_gnt_o || wr_gnt_o) begin
            prefer_rd_d = wr_gnt_o;
        end
    end

    // Preference flag register; reads are preferred out of reset.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            prefer_rd_q <= 1'b1;
        end else begin
            prefer_rd_q <= prefer_rd_d;
        end
    end

endmodule

// File: rtl/sda_kernel_reg_bridge.sv
// sda_kernel_reg_bridge: AXI4-Lite control slave to simple register bus.
// One register transaction at a time; regReq is held until regAck and is
// always low for at least one cycle between transactions (the RESP state).
// Optional build macro SDA_REG_BRIDGE_TIMEOUT_EN adds a regAck timeout that
// answers with SLVERR after TimeoutCycles cycles of unacknowledged regReq.
//
// Handshakes: an AXI transfer happens on a rising clk edge where valid and
// ready are both high. Readies are only ever raised in IDLE for the granted
// channel (AW and W together), and B/R valids stay high with stable payload
// until the matching ready is sampled high.
module sda_kernel_reg_bridge
    import sda_reg_bridge_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = 8,
    parameter logic [15:0] TimeoutCycles = 16'd255
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [RegAddrWidth-1:0] s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [RegAddrWidth-1:0] s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    regReq,
    input  logic                    regAck,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic [31:0]             regRData
);

    localparam logic [RegAddrWidth-1:0] ADDR_MASK = {{(RegAddrWidth-2){1'b1}}, 2'b00};

    bridge_state_e           state_q;
    bridge_state_e           state_d;
    logic                    rd_gnt;
    logic                    wr_gnt;
    logic                    timeout_hit;
    logic                    wr_q;
    logic [RegAddrWidth-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [1:0]              resp_q;
    logic [31:0]             rdata_q;

    // Arbitration only runs in IDLE and is held off while reset is asserted,
    // so no ready can rise during reset.
    sda_reg_bridge_arb u_arb (
        .clk      (clk),
        .srst     (srst),
        .en_i     ((state_q == IDLE) && !srst),
        .rd_req_i (s_arvalid),
        .wr_req_i (s_awvalid && s_wvalid),
        .rd_gnt_o (rd_gnt),
        .wr_gnt_o (wr_gnt)
    );

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Count cycles spent in ISSUE; zero whenever the bridge is not issuing.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // The last allowed ISSUE cycle is the one where the count equals
    // TimeoutCycles-1, so regReq is high for exactly TimeoutCycles cycles.
    assign timeout_hit = (state_q == ISSUE) && !regAck &&
                         (tmo_cnt_q == (TimeoutCycles - 16'd1));
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TimeoutCycles;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant -> ISSUE, ack or timeout -> RESP, ready -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_gnt || wr_gnt) state_d = ISSUE;
            ISSUE:   if (regAck || timeout_hit) state_d = RESP;
            RESP:    if (wr_q ? s_bready : s_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: readies from the grant, regReq in ISSUE, valids in RESP.
    always_comb begin
        s_arready = rd_gnt;
        s_awready = wr_gnt;
        s_wready  = wr_gnt;
        regReq    = (state_q == ISSUE);
        s_bvalid  = (state_q == RESP) && wr_q;
        s_rvalid  = (state_q == RESP) && !wr_q;
        s_bresp   = s_bvalid ? resp_q : RESP_OKAY;
        s_rresp   = s_rvalid ? resp_q : RESP_OKAY;
        s_rdata   = s_rvalid ? rdata_q : 32'h0;
    end

    // Latch the granted request, then the register-bus result in ISSUE.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            if (wr_gnt) begin
                wr_q    <= 1'b1;
                addr_q  <= s_awaddr & ADDR_MASK;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end else if (rd_gnt) begin
                wr_q    <= 1'b0;
                addr_q  <= s_araddr & ADDR_MASK;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
            // An ack in the expiry cycle still wins and answers OKAY.
            if (state_q == ISSUE) begin
                if (regAck) begin
                    resp_q  <= RESP_OKAY;
                    rdata_q <= wr_q ? 32'h0 : regRData;
                end else if (timeout_hit) begin
                    resp_q  <= RESP_SLVERR;
                    rdata_q <= 32'h0;
                end
            end
        end
    end

    assign regWriteEn = wr_q;
    assign regAddr    = addr_q;
    assign regWData   = wdata_q;
    assign regWStrb   = wstrb_q;

endmodule

// File: tb/tb_sda_kernel_reg_bridge.sv
// tb_sda_kernel_reg_bridge: directed bench for the AXI-Lite register bridge.
// A register-block model answers regReq after a programmable delay; expected
// AXI responses are queued when a transaction is driven and compared when
// the DUT presents them.
module tb_sda_kernel_reg_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [7:0]  s_awaddr, s_araddr, regAddr;
  logic [31:0] s_wdata, s_rdata, regWData, regRData;
  logic [3:0]  s_wstrb, regWStrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        regReq, regAck, regWriteEn;

  sda_kernel_reg_bridge #(.RegAddrWidth(8), .TimeoutCycles(16'd8)) dut (
    .clk(clk), .srst(srst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn), .regAddr(regAddr),
    .regWData(regWData), .regWStrb(regWStrb), .regRData(regRData)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [34:0] exp_q[$];      // {is_write, resp[1:0], rdata[31:0]}
  logic [31:0] mem[64];
  int          ack_dly;
  bit          ack_en;
  int          req_cnt;
  int          req_hi;
  int          rises;
  logic        prev_req;
  logic        ar_hs, aw_hs;
  logic [2:0]  rdy_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input logic [34:0] obs);
    logic [34:0] e;
    check("resp_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("axi_response", obs, e);
    end
  endtask

  // One clock cycle: register-block model, invariants, response scoreboard,
  // handshake flags; returns at the next falling edge.
  task automatic tick();
    int idx;
    #1;
    if (srst || !regReq) begin
      req_cnt = 0; regAck = 1'b0; regRData = 32'h0;
    end else begin
      req_cnt++;
      if (ack_en && req_cnt == ack_dly + 1) begin
        regAck = 1'b1;
        idx = int'(regAddr[7:2]);
        if (regWriteEn) begin
          regRData = 32'h0;
          for (int b = 0; b < 4; b++)
            if (regWStrb[b]) mem[idx][b*8 +: 8] = regWData[b*8 +: 8];
        end else begin
          regRData = mem[idx];
        end
      end else begin
        regAck = 1'b0; regRData = 32'h0;
      end
    end
    if (!srst) begin
      if (s_rvalid || s_bvalid) check("req_low_in_resp", regReq, 0);
      if (regReq || s_rvalid || s_bvalid)
        check("no_ready_when_busy", {s_arready, s_awready, s_wready}, 3'b000);
      if (regReq) req_hi++;
      if (regReq && !prev_req) rises++;
      if (s_rvalid && s_rready) pop_check({1'b0, s_rresp, s_rdata});
      if (s_bvalid && s_bready) pop_check({1'b1, s_bresp, 32'h0});
    end
    prev_req = regReq;
    ar_hs    = s_arvalid && s_arready;
    aw_hs    = s_awvalid && s_wvalid && s_awready && s_wready;
    rdy_seen = {s_arready, s_awready, s_wready};
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ar_hs();
    int n = 0;
    do begin tick(); n++; end while (!ar_hs && n < 50);
    check("ar_handshake", ar_hs, 1);
    s_arvalid = 1'b0;
  endtask

  task automatic wait_aw_hs();
    int n = 0;
    do begin tick(); n++; end while (!aw_hs && n < 50);
    check("aw_w_handshake", aw_hs, 1);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_q.push_back({1'b0, resp, data});
    s_araddr = addr; s_arvalid = 1'b1;
    wait_ar_hs();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_aw_hs();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    check("drain_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          nr;
    int          nw;
    logic [3:0]  seq;

    srst = 1'b1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
    regAck = 0; regRData = 0; prev_req = 0; req_cnt = 0; req_hi = 0; rises = 0;
    ack_en = 1; ack_dly = 2;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_000A; mem[1] = 32'hFFFF_FFFF;
    mem[3] = 32'h0C0C_0C0C; mem[4] = 32'h4444_4444;

    // Reset with every request channel valid: nothing may be accepted.
    s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
    repeat (3) tick();
    #1;
    check("rst_readies", {s_arready, s_awready, s_wready}, 3'b000);
    check("rst_valids", {s_bvalid, s_rvalid, regReq}, 3'b000);
    check("rst_reg_bus", {regWriteEn, regAddr, regWData, regWStrb}, 45'h0);
    check("rst_resp_data", {s_bresp, s_rresp, s_rdata}, 36'h0);
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    srst = 1'b0;
    tick();

    // Read 0x00 against a block that acks two cycles after regReq rises.
    req_hi = 0;
    do_read(8'h00, 32'h0000_000A, 2'b00);
    check("t1_regReq", regReq, 1);
    check("t1_regAddr", regAddr, 8'h00);
    check("t1_regWriteEn", regWriteEn, 0);
    check("t1_regWStrb", regWStrb, 4'h0);
    check("t1_rdata_zero_no_valid", s_rdata, 32'h0);
    n = 0;
    while (!s_rvalid && n < 20) begin tick(); n++; end
    check("t1_rvalid_latency", n, 3);
    wait_drain(20);
    check("t1_req_cycles", req_hi, 3);

    // Write 0x04 with AW presented three cycles ahead of W.
    s_awaddr = 8'h04; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1;
    repeat (3) begin tick(); check("t2_aw_alone_no_ready", rdy_seen, 3'b000); end
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    s_wvalid = 1;
    wait_aw_hs();
    check("t2_regWriteEn", regWriteEn, 1);
    check("t2_regAddr", regAddr, 8'h04);
    check("t2_regWData", regWData, 32'h1);
    check("t2_regWStrb", regWStrb, 4'hF);
    wait_drain(20);
    do_read(8'h06, 32'h1, 2'b00);
    check("t2_addr_aligned", regAddr, 8'h04);
    wait_drain(20);
    do_write(8'h04, 32'hAABB_CCDD, 4'h5);
    wait_drain(20);
    do_read(8'h04, 32'h00BB_00DD, 2'b00);
    wait_drain(20);

    // Contention from reset: grants must alternate R, W, R, W.
    srst = 1'b1; tick(); srst = 1'b0; tick();
    rises = 0; seq = 4'h0; nr = 0; nw = 0; n = 0;
    exp_q.push_back({1'b0, 2'b00, 32'h0C0C_0C0C});
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    exp_q.push_back({1'b0, 2'b00, 32'h0C0C_0C0C});
    exp_q.push_back({1'b1, 2'b00, 32'h0});
    s_araddr = 8'h0C; s_arvalid = 1;
    s_awaddr = 8'h08; s_wdata = 32'h11; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    while ((nr < 2 || nw < 2) && n < 200) begin
      tick(); n++;
      if (ar_hs) begin
        seq = {seq[2:0], 1'b0}; nr++;
        if (nr == 2) s_arvalid = 0;
      end
      if (aw_hs) begin
        seq = {seq[2:0], 1'b1}; nw++; s_wdata = 32'h22;
        if (nw == 2) begin s_awvalid = 0; s_wvalid = 0; end
      end
    end
    check("t3_grant_order", seq, 4'b0101);
    wait_drain(50);
    check("t3_req_rises", rises, 4);
    do_read(8'h08, 32'h22, 2'b00);
    wait_drain(20);

    // Read response held off by s_rready low for five cycles.
    s_rready = 0;
    do_read(8'h00, 32'h0000_000A, 2'b00);
    n = 0;
    while (!s_rvalid && n < 20) begin tick(); n++; end
    check("t4_rvalid_seen", s_rvalid, 1);
    exp_q.push_back({1'b0, 2'b00, 32'h0C0C_0C0C});
    s_araddr = 8'h0C; s_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      check("t4_rvalid_held", s_rvalid, 1);
      check("t4_rdata_held", s_rdata, 32'h0000_000A);
      check("t4_regReq_low", regReq, 0);
      tick();
      check("t4_no_ready", rdy_seen, 3'b000);
    end
    s_rready = 1;
    wait_ar_hs();
    wait_drain(20);

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    // No ack: SLVERR after eight regReq cycles, then a normal read.
    ack_en = 0; req_hi = 0;
    do_read(8'h10, 32'h0, 2'b10);
    wait_drain(50);
    check("t5_req_cycles", req_hi, 8);
    ack_en = 1;
    do_read(8'h10, 32'h4444_4444, 2'b00);
    wait_drain(20);
`endif

    // Reset while ISSUE is waiting on a slow block.
    ack_dly = 5;
    do_read(8'h00, 32'h0000_000A, 2'b00);
    tick();
    check("t6_in_issue", regReq, 1);
    s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
    srst = 1'b1;
    #1;
    check("t6_regReq_async", regReq, 0);
    check("t6_readies_async", {s_arready, s_awready, s_wready}, 3'b000);
    check("t6_valids_async", {s_rvalid, s_bvalid}, 2'b00);
    exp_q.delete();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    tick(); tick();
    srst = 1'b0;
    repeat (8) tick();
    check("t6_no_stale_resp", {s_rvalid, s_bvalid, regReq}, 3'b000);
    ack_dly = 2;
    do_read(8'h0C, 32'h0C0C_0C0C, 2'b00);
    wait_drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
